multi_timer: RTL

Parametrised multi-channel timer peripheral on the memory-mapped CS_N/RD_N/WR_N bus, the next generation of the single-compare timer. Each of NUM_CH channels has its own counter, compare register, clock prescaler, periodic/one-shot mode and interrupt enable. Channels share one write-1-to-clear status register and one active-low interrupt line to the processor.

---
 rtl/timer_pkg.sv | 17 +
 rtl/timer_channel.sv | 82 ++++++++
 rtl/multi_timer.sv | 98 +++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared register map and CTRL field positions for the multi-channel timer.
package timer_pkg;

  localparam logic [7:0] RegCtrl     = 8'h00;
  localparam logic [7:0] RegCompare  = 8'h04;
  localparam logic [7:0] RegCount    = 8'h08;
  localparam logic [7:0] RegPrescale = 8'h0C;
  localparam logic [7:0] RegStatus   = 8'h00;

  localparam logic [3:0] GlobalCh = 4'hF;

  localparam int unsigned CtrlW       = 3;
  localparam int unsigned CtrlEn      = 0;
  localparam int unsigned CtrlOneshot = 1;
  localparam int unsigned CtrlIe      = 2;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/COMPARE/PRESCALE registers, prescaler and counter.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_ctrl,
  input  logic               wr_compare,
  input  logic               wr_prescale,
  input  logic [CtrlW-1:0]   ctrl_wdata,
  input  logic [CNT_W-1:0]   compare_wdata,
  input  logic [PRESC_W-1:0] prescale_wdata,
  output logic [CtrlW-1:0]   ctrl,
  output logic [CNT_W-1:0]   compare,
  output logic [CNT_W-1:0]   count,
  output logic [PRESC_W-1:0] prescale,
  output logic               match
);

  logic [CtrlW-1:0]   ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   compare_q, compare_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PRESC_W-1:0] prescale_q, prescale_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               tick;

  always_comb begin
    ctrl_d     = ctrl_q;
    compare_d  = compare_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    tick       = ctrl_q[CtrlEn] && (pcnt_q == prescale_q);
    match      = tick && (count_q == compare_q);

    if (ctrl_q[CtrlEn]) begin
      if (tick) begin
        pcnt_d  = '0;
        count_d = match ? '0 : count_q + CNT_W'(1);
      end else begin
        pcnt_d = pcnt_q + PRESC_W'(1);
      end
    end
    if (match && ctrl_q[CtrlOneshot]) ctrl_d[CtrlEn] = 1'b0;

    // A software CTRL write overrides a coincident one-shot disable.
    if (wr_ctrl) begin
      ctrl_d = ctrl_wdata;
      if (!ctrl_q[CtrlEn] && ctrl_wdata[CtrlEn]) begin
        pcnt_d  = '0;
        count_d = '0;
      end
    end
    if (wr_compare)  compare_d  = compare_wdata;
    if (wr_prescale) prescale_d = prescale_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q     <= '0;
      compare_q  <= '1;
      count_q    <= '0;
      prescale_q <= '0;
      pcnt_q     <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      compare_q  <= compare_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
    end
  end

  assign ctrl     = ctrl_q;
  assign compare  = compare_q;
  assign count    = count_q;
  assign prescale = prescale_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer: bus decode, shared W1C status, read mux and interrupt.
module multi_timer
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CS_N,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic [11:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Intr
);

  logic [3:0] chan;
  logic [7:0] regsel;
  logic       wr, rd, wr_status;

  logic [CtrlW-1:0]   ctrl     [NUM_CH];
  logic [CNT_W-1:0]   compare  [NUM_CH];
  logic [CNT_W-1:0]   count    [NUM_CH];
  logic [PRESC_W-1:0] prescale [NUM_CH];
  logic [NUM_CH-1:0]  match, ie;
  logic [NUM_CH-1:0]  pending_q, pending_d;

  // Data bits above every field width are intentionally dropped.
  logic unused_data;
  assign unused_data = ^DataIn;

  assign chan      = Addr[11:8];
  assign regsel    = Addr[7:0];
  assign wr        = !CS_N && !WR_N;
  assign rd        = !CS_N && !RD_N;
  assign wr_status = wr && (chan == GlobalCh) && (regsel == RegStatus);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    assign sel   = wr && (chan == 4'(c));
    assign ie[c] = ctrl[c][CtrlIe];

    timer_channel #(
      .CNT_W   (CNT_W),
      .PRESC_W (PRESC_W)
    ) u_channel (
      .clk            (clk),
      .reset          (reset),
      .wr_ctrl        (sel && (regsel == RegCtrl)),
      .wr_compare     (sel && (regsel == RegCompare)),
      .wr_prescale    (sel && (regsel == RegPrescale)),
      .ctrl_wdata     (DataIn[CtrlW-1:0]),
      .compare_wdata  (DataIn[CNT_W-1:0]),
      .prescale_wdata (DataIn[PRESC_W-1:0]),
      .ctrl           (ctrl[c]),
      .compare        (compare[c]),
      .count          (count[c]),
      .prescale       (prescale[c]),
      .match          (match[c])
    );
  end

  // Hardware set takes priority over a same-cycle software clear.
  always_comb begin
    pending_d = pending_q;
    if (wr_status) pending_d = pending_d & ~DataIn[NUM_CH-1:0];
    pending_d = pending_d | match;
  end

  always_ff @(posedge clk) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign Intr = !reset ? 1'b1 : ~|(pending_q & ie);

  always_comb begin
    DataOut = '0;
    if (rd && reset) begin
      if (chan == GlobalCh && regsel == RegStatus) DataOut = 32'(pending_q);
      for (int c = 0; c < NUM_CH; c++) begin
        if (chan == 4'(c)) begin
          case (regsel)
            RegCtrl:     DataOut = 32'(ctrl[c]);
            RegCompare:  DataOut = 32'(compare[c]);
            RegCount:    DataOut = 32'(count[c]);
            RegPrescale: DataOut = 32'(prescale[c]);
            default:     DataOut = '0;
          endcase
        end
      end
    end
  end

endmodule
